// File: rtl/rst_sequencer_pkg.sv
// rtl/rst_sequencer_pkg.sv - shared constants and types for the staged reset-release sequencer
package rst_sequencer_pkg;

    localparam int BUS_WIDTH      = 32;
    localparam int BUS_ACC_WIDTH  = 2;
    localparam int RST_SEQ_SIZE   = 8;
    localparam int RST_SEQ_ADDR_W = $clog2(RST_SEQ_SIZE);

    localparam logic [RST_SEQ_ADDR_W-1:0] RST_SEQ_DLY  = 3'd0;
    localparam logic [RST_SEQ_ADDR_W-1:0] RST_SEQ_STAT = 3'd4;

    // access size encoding on the acc bus field
    localparam logic [BUS_ACC_WIDTH-1:0] ACC_1B = 2'd0;
    localparam logic [BUS_ACC_WIDTH-1:0] ACC_2B = 2'd1;
    localparam logic [BUS_ACC_WIDTH-1:0] ACC_4B = 2'd2;

    localparam int          STAT_DONE_BIT       = 8;
    localparam logic [31:0] RST_SEQ_DEFAULT_DLY = 32'h0F0F_0F0F;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_SEQ  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - releases N_DOM reset domains in index order with programmable per-stage delays
module rst_sequencer
    import rst_sequencer_pkg::*;
#(
    parameter int          N_DOM       = 4,
    parameter int          DLY_W       = 8,
    parameter logic [31:0] DEFAULT_DLY = RST_SEQ_DEFAULT_DLY
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic [N_DOM-1:0]          dom_rst_ob,
    input  logic [RST_SEQ_ADDR_W-1:0] addr,
    input  logic                      w_rb,
    input  logic [BUS_ACC_WIDTH-1:0]  acc,
    output logic [BUS_WIDTH-1:0]      rdata,
    input  logic [BUS_WIDTH-1:0]      wdata,
    input  logic                      req,
    output logic                      resp,
    output logic                      fault
);

    localparam int STG_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    // power-on values come from declaration initialisers; DLY is never touched by rst_n
    logic [BUS_WIDTH-1:0] dly    = DEFAULT_DLY;
    seq_state_e           state  = ST_HOLD;
    logic [STG_W-1:0]     stage  = '0;
    logic [DLY_W-1:0]     cnt    = '0;
    logic [N_DOM-1:0]     dom_q  = '0;
    logic                 resp_q = 1'b0;
    logic [BUS_WIDTH-1:0] rdata_q;

    logic                 is_dly;
    logic                 is_stat;
    logic                 valid;
    logic [BUS_WIDTH-1:0] stat_word;
    logic [DLY_W-1:0]     cur_dly;

    assign is_dly  = (addr == RST_SEQ_DLY);
    assign is_stat = (addr == RST_SEQ_STAT);
    assign valid   = (is_dly && acc == ACC_4B) || (is_stat && acc == ACC_2B && !w_rb);
    assign fault   = req & ~valid;
    assign cur_dly = dly[int'(stage)*DLY_W +: DLY_W];

    always_comb begin
        stat_word                = '0;
        stat_word[N_DOM-1:0]     = dom_q;
        stat_word[STAT_DONE_BIT] = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_HOLD;
            stage  <= '0;
            cnt    <= '0;
            dom_q  <= '0;
            resp_q <= 1'b0;
        end else begin
            resp_q <= req & valid;
            // only DLY is writable, so a valid write always targets it
            if (req && valid) begin
                if (w_rb) begin
                    dly <= wdata;
                end else begin
                    rdata_q <= is_dly ? dly : stat_word;
                end
            end

            case (state)
                ST_HOLD: begin
                    state <= ST_SEQ;
                    stage <= '0;
                    cnt   <= '0;
                end
                ST_SEQ: begin
                    if (cnt == cur_dly) begin
                        dom_q[stage] <= 1'b1;
                        cnt          <= '0;
                        stage        <= stage + 1'b1;
                        if (stage == STG_W'(N_DOM - 1)) begin
                            state <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

    assign dom_rst_ob = dom_q;
    assign resp       = resp_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - self-checking bench for rst_sequencer
module tb_rst_sequencer;
    import rst_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  dom_rst_ob;
    logic [2:0]  addr = '0;
    logic        w_rb = 1'b0;
    logic [1:0]  acc = ACC_4B;
    logic [31:0] rdata;
    logic [31:0] wdata = '0;
    logic        req = 1'b0;
    logic        resp;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    rst_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dom_rst_ob (dom_rst_ob),
        .addr       (addr),
        .w_rb       (w_rb),
        .acc        (acc),
        .rdata      (rdata),
        .wdata      (wdata),
        .req        (req),
        .resp       (resp),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  a;
        logic        w;
        logic [1:0]  sz;
        logic [31:0] wd;
        logic        ef;
        logic        er;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // release mask expected t edges after rst_n rose: domain k is out once t >= sum_{j<=k}(d[j]+1)
    function automatic logic [3:0] exp_mask(input int t, input logic [31:0] d);
        int sum = 0;
        exp_mask = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            sum += int'(d[k*8 +: 8]) + 1;
            if (t >= sum) exp_mask[k] = 1'b1;
        end
    endfunction

    function automatic int total_time(input logic [31:0] d);
        total_time = 0;
        for (int k = 0; k < 4; k++) total_time += int'(d[k*8 +: 8]) + 1;
    endfunction

    task automatic bus(input logic [2:0] a, input logic w, input logic [1:0] sz, input logic [31:0] wd,
                       output logic f, output logic r, output logic [31:0] rd);
        addr  = a;
        w_rb  = w;
        acc   = sz;
        wdata = wd;
        req   = 1'b1;
        #1 f = fault;
        tick();
        r  = resp;
        rd = rdata;
        req = 1'b0;
    endtask

    task automatic write_dly(input logic [31:0] d);
        logic f, r;
        logic [31:0] rd;
        bus(RST_SEQ_DLY, 1'b1, ACC_4B, d, f, r, rd);
        chk("dly_write_resp", {31'd0, r}, 32'd1);
    endtask

    task automatic read_stat(input string name, input logic [31:0] exp);
        logic f, r;
        logic [31:0] rd;
        bus(RST_SEQ_STAT, 1'b0, ACC_2B, '0, f, r, rd);
        chk({name, "_resp"}, {31'd0, r}, 32'd1);
        chk(name, rd, exp);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_hold_dom", {28'd0, dom_rst_ob}, 32'd0);
        chk("rst_hold_resp", {31'd0, resp}, 32'd0);
        rst_n = 1'b1;
    endtask

    // rst_n has just risen; edges t = t0..end checked against the model
    task automatic release_check(input string name, input logic [31:0] d, input int t0);
        int last = total_time(d) + 2;
        for (int t = t0; t <= last; t++) begin
            tick();
            chk(name, {28'd0, dom_rst_ob}, {28'd0, exp_mask(t, d)});
        end
    endtask

    initial begin
        logic        f, r;
        logic [31:0] rd;
        logic [31:0] d;

        #1;
        chk("poweron_dom", {28'd0, dom_rst_ob}, 32'd0);
        chk("poweron_resp", {31'd0, resp}, 32'd0);

        // power-on release without a reset pulse; first edge is t=0
        for (int t = 0; t <= 68; t++) begin
            tick();
            chk("poweron_seq", {28'd0, dom_rst_ob}, {28'd0, exp_mask(t, RST_SEQ_DEFAULT_DLY)});
        end
        read_stat("poweron_stat", 32'h0000_010F);

        vecs[0]  = '{3'd0, 1'b1, ACC_4B, 32'h0302_0100, 1'b0, 1'b1, 32'h0000_010F};
        vecs[1]  = '{3'd0, 1'b0, ACC_4B, 32'h0,         1'b0, 1'b1, 32'h0302_0100};
        vecs[2]  = '{3'd2, 1'b0, ACC_4B, 32'h0,         1'b1, 1'b0, 32'h0302_0100};
        vecs[3]  = '{3'd4, 1'b1, ACC_2B, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0302_0100};
        vecs[4]  = '{3'd4, 1'b0, ACC_2B, 32'h0,         1'b0, 1'b1, 32'h0000_010F};
        vecs[5]  = '{3'd0, 1'b0, ACC_2B, 32'h0,         1'b1, 1'b0, 32'h0000_010F};
        vecs[6]  = '{3'd0, 1'b1, ACC_2B, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0000_010F};
        vecs[7]  = '{3'd0, 1'b0, ACC_4B, 32'h0,         1'b0, 1'b1, 32'h0302_0100};
        vecs[8]  = '{3'd4, 1'b0, ACC_4B, 32'h0,         1'b1, 1'b0, 32'h0302_0100};
        vecs[9]  = '{3'd6, 1'b0, ACC_2B, 32'h0,         1'b1, 1'b0, 32'h0302_0100};
        vecs[10] = '{3'd4, 1'b0, ACC_1B, 32'h0,         1'b1, 1'b0, 32'h0302_0100};
        vecs[11] = '{3'd0, 1'b1, ACC_1B, 32'h0000_00FF, 1'b1, 1'b0, 32'h0302_0100};

        for (int i = 0; i < 12; i++) begin
            bus(vecs[i].a, vecs[i].w, vecs[i].sz, vecs[i].wd, f, r, rd);
            chk($sformatf("vec%0d_fault", i), {31'd0, f}, {31'd0, vecs[i].ef});
            chk($sformatf("vec%0d_resp", i), {31'd0, r}, {31'd0, vecs[i].er});
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].erd);
        end

        // staged release after a reset pulse; DLY persists across reset
        pulse_reset();
        release_check("seq_0302", 32'h0302_0100, 0);
        bus(RST_SEQ_DLY, 1'b0, ACC_4B, '0, f, r, rd);
        chk("dly_persist", rd, 32'h0302_0100);

        // all-zero delays: one domain per edge
        write_dly(32'h0);
        pulse_reset();
        release_check("seq_zero", 32'h0, 0);
        read_stat("zero_stat", 32'h0000_010F);

        // reset the cycle after domain 1 releases
        write_dly(32'h0302_0100);
        pulse_reset();
        for (int t = 0; t <= 3; t++) tick();
        chk("mid_pre", {28'd0, dom_rst_ob}, 32'h3);
        rst_n = 1'b0;
        tick();
        chk("mid_rst", {28'd0, dom_rst_ob}, 32'h0);
        rst_n = 1'b1;
        release_check("mid_restart", 32'h0302_0100, 0);

        // reset lands exactly on the edge that would release domain 2
        pulse_reset();
        for (int t = 0; t <= 5; t++) tick();
        chk("edge_pre", {28'd0, dom_rst_ob}, 32'h3);
        rst_n = 1'b0;
        tick();
        chk("edge_rst", {28'd0, dom_rst_ob}, 32'h0);
        rst_n = 1'b1;
        release_check("edge_restart", 32'h0302_0100, 0);

        // live STAT read during SEQ: the read occupies edge 4
        pulse_reset();
        for (int t = 0; t <= 3; t++) tick();
        bus(RST_SEQ_STAT, 1'b0, ACC_2B, '0, f, r, rd);
        chk("seq_stat_resp", {31'd0, r}, 32'd1);
        chk("seq_stat_partial", rd, 32'h0000_0003);
        chk("seq_stat_dom", {28'd0, dom_rst_ob}, {28'd0, exp_mask(4, 32'h0302_0100)});
        release_check("seq_stat_rest", 32'h0302_0100, 5);

        // valid DLY write coinciding with rst_n low is dropped
        rst_n = 1'b0;
        bus(RST_SEQ_DLY, 1'b1, ACC_4B, 32'h1111_1111, f, r, rd);
        chk("simul_resp", {31'd0, r}, 32'd0);
        rst_n = 1'b1;
        tick();
        bus(RST_SEQ_DLY, 1'b0, ACC_4B, '0, f, r, rd);
        chk("simul_dly", rd, 32'h0302_0100);

        // random delays against the timing model, including a maximum-length stage
        for (int it = 0; it < 6; it++) begin
            d = {8'($urandom_range(0, 30)), 8'($urandom_range(0, 30)),
                 8'($urandom_range(0, 30)), 8'($urandom_range(0, 30))};
            if (it == 5) d[15:8] = 8'hFF;
            write_dly(d);
            pulse_reset();
            release_check($sformatf("rand%0d", it), d, 0);
            read_stat($sformatf("rand%0d_stat", it), 32'h0000_010F);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Staged reset-release sequencer placed directly behind the reset controller.
- Takes the aggregate active-low reset for one reset line and releases N_DOM downstream domains one at a time, in index order (domain 0 first).
- A per-stage cycle delay is programmable over the peripheral bus.
- Delay configuration survives reset, so software can retune power-up ordering for the next reset.

Parameters:
- N_DOM, 4, number of sequenced domains; 1..4.
- DLY_W, 8, width of each per-stage delay field; N_DOM*DLY_W <= 32.
- DEFAULT_DLY, 32'h0F0F0F0F, power-on value of the DLY register; byte k = stage k delay.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low; driven by one rst_controller output bit.
- dom_rst_ob  out  N_DOM  per-domain reset, lo active.
- addr  in  $clog2(`RST_SEQ_SIZE)  bus register address.
- w_rb  in  1  1 = write, 0 = read.
- acc  in  `BUS_ACC_WIDTH  access size.
- rdata  out  `BUS_WIDTH  read data.
- wdata  in  `BUS_WIDTH  write data.
- req  in  1  bus request.
- resp  out  1  bus response, one cycle after an accepted req.
- fault  out  1  combinational, req & invalid.

Behaviour:
- Reset is synchronous and active-low on clk only; no other reset input.
- Power-on (FPGA init values):
  - dom_rst_ob = all 0.
  - resp = 0.
  - state = HOLD.
  - DLY = DEFAULT_DLY.
  - rdata is undefined until the first read.
- Register map:
  - DLY @0: 4B, RW. Bits [k*DLY_W +: DLY_W] hold stage k delay.
  - STAT @4: 2B, R. Bits [N_DOM-1:0] = dom_rst_ob; bit 8 = DONE; all other bits 0.
- Invalid access: addr not in {0,4}; acc != 4B at addr 0; acc != 2B at addr 4; write to addr 4. fault = req & invalid, same cycle.
- Invalid access effects: no register change, resp = 0 the next cycle, rdata holds its previous value.
- Valid access:
  - resp = 1 exactly one cycle after req; rdata is updated on the same edge.
  - Writes to DLY update it on that edge and take effect from the next sequence start. Unused high bits of DLY are stored but ignored.
- rst_n = 0 at an edge:
  - State goes to HOLD; stage = 0; cnt = 0; dom_rst_ob = 0; resp = 0.
  - DLY is NOT reset.
  - Any bus req in that cycle is dropped.
- FSM states HOLD, SEQ, DONE:
  - HOLD: on the first edge with rst_n = 1 (call it edge t=0), go to SEQ with stage = 0, cnt = 0.
  - SEQ, each edge with rst_n = 1: if cnt == DLY[stage], then dom_rst_ob[stage] <= 1, cnt <= 0, stage <= stage + 1. Otherwise cnt <= cnt + 1.
  - SEQ exits to DONE on the edge that releases stage N_DOM-1.
  - DONE: hold all domains released until rst_n = 0.
- Timing: domain k is released at edge t = sum over j = 0..k of (DLY[j] + 1).
- Delay limits:
  - DLY field = 0 gives a 1-cycle stage.
  - Maximum stage is 2^DLY_W cycles.
  - cnt never wraps because it compares for equality against a DLY_W-wide value.
- Once released, a domain never re-asserts except through rst_n.
- Domains release monotonically: dom_rst_ob is always of the form 0..01..1, with the low index released first.
- Reset mid-sequence (any stage, including the edge on which a release would occur): rst_n wins, all domains re-assert, and the sequence restarts from stage 0 with the current DLY.
- Bus accesses are accepted in every state with rst_n = 1, including SEQ; reads of STAT return the live status.

Decomposition:
- Add to femto.vh:
  - `RST_SEQ_SIZE (8).
  - Register offsets `RST_SEQ_DLY (0) and `RST_SEQ_STAT (4).
  - STAT DONE bit index (8).
  - FSM state encodings (HOLD, SEQ, DONE).
  - Default-delay constant.
- No sub-module: FSM, counter and bus decode stay in one module.

Test Plan:
- Power-on with no rst_n pulse: dom_rst_ob = 0000 at t=0. With DEFAULT_DLY, domains release at edges 16, 32, 48, 64. STAT then reads 0x010F with resp at the next cycle.
- Write DLY = 0x03020100 (4B, addr 0) -> resp = 1 next cycle. Pulse rst_n low for 2 cycles. Domains release at edges 1, 3, 6, 10 after rst_n rises. Read DLY -> 0x03020100, so it persisted across reset.
- DLY = 0, rst_n pulse -> dom_rst_ob steps 0001, 0011, 0111, 1111 on edges 1, 2, 3, 4; STAT bit 8 = 1 from edge 4.
- DLY = 0x03020100, drop rst_n the cycle after domain 1 releases -> dom_rst_ob = 0000 at the next edge. On rst_n rising, release timing restarts at 1, 3, 6, 10.
- Bus faults:
  - read addr 2 -> fault = 1 same cycle, resp = 0 next cycle.
  - write addr 4 (2B) -> fault = 1, STAT unchanged.
  - read addr 0 with 2B -> fault = 1.
  - write addr 0 with 2B -> fault = 1, DLY unchanged.
- Simultaneous events: valid DLY write in the same cycle rst_n = 0 -> write dropped, resp = 0. req during SEQ reading STAT returns the current partial mask, e.g. 0x0003.
